// File: rtl/pcm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pcm_pkg                                                |
// | Description : Shared definitions for the PCM framer and deframer:    |
// |               FSM state encoding and default alignment/idle bytes.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } pcm_state_t;

  localparam logic [7:0] c_sync_word = 8'h9B;
  localparam logic [7:0] c_idle_code = 8'h00;

endpackage
`default_nettype wire

// File: rtl/pcm_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pcm_fifo2                                              |
// | Description : 2-entry, 8-bit input FIFO with occupancy count. The    |
// |               producer only pushes when count < 2 and the consumer   |
// |               only pops when count > 0.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pcm_fifo2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_din,
  input  logic       i_pop,
  output logic [7:0] o_dout,
  output logic [1:0] o_count
);

  logic [7:0] r_mem [0:1];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= 8'h00;
      r_mem[1] <= 8'h00;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pcm_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pcm_framer                                             |
// | Description : Serialises PCM bytes into frames of one sync byte      |
// |               followed by SLOTS data bytes, MSB first, each bit held |
// |               BIT_DIV clocks. Empty slots carry IDLE_CODE.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pcm_framer
  import pcm_pkg::*;
#(
  parameter int         SLOTS     = 4,
  parameter int         BIT_DIV   = 8,
  parameter logic [7:0] SYNC_WORD = c_sync_word,
  parameter logic [7:0] IDLE_CODE = c_idle_code
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pcm_in,
  input  logic       pcm_valid,
  output logic       pcm_ready,
  output logic       tx_bit,
  output logic       tx_bit_en,
  output logic       frame_start,
  output logic       underrun
);

  localparam int c_div_w  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int c_slot_w = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(BIT_DIV - 1);
  localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SLOTS - 1);

  pcm_state_t          r_state;
  pcm_state_t          w_next_state;
  logic [c_div_w-1:0]  r_div;
  logic [2:0]          r_bit;
  logic [c_slot_w-1:0] r_slot;
  logic [7:0]          r_shift;
  logic                r_underrun;

  logic [1:0] w_fifo_count;
  logic [7:0] w_fifo_dout;
  logic       w_fifo_has_data;
  logic       w_push;
  logic       w_pop;
  logic       w_byte_end;
  logic       w_last_slot;
  logic       w_load_sync;
  logic       w_load_data;
  logic       w_go_idle;

  assign w_fifo_has_data = (w_fifo_count != 2'd0);
  assign w_push          = pcm_valid & pcm_ready;
  assign w_byte_end      = (r_state != ST_IDLE) && (r_div == c_div_last) && (r_bit == 3'd7);
  assign w_last_slot     = (r_state == ST_DATA) && (r_slot == c_slot_last);

  pcm_fifo2 u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_din   (pcm_in),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode, byte-load controls and line outputs; reset forces all outputs low.
  always_comb begin
    w_next_state = r_state;
    w_load_sync  = 1'b0;
    w_load_data  = 1'b0;
    w_go_idle    = 1'b0;
    w_pop        = 1'b0;
    pcm_ready    = 1'b0;
    tx_bit       = 1'b0;
    tx_bit_en    = 1'b0;
    frame_start  = 1'b0;
    underrun     = 1'b0;

    if (!reset) begin
      pcm_ready = (w_fifo_count < 2'd2);
      underrun  = r_underrun;
      if (r_state != ST_IDLE) begin
        tx_bit      = r_shift[7];
        tx_bit_en   = (r_div == '0);
        frame_start = (r_state == ST_SYNC) && (r_div == '0) && (r_bit == 3'd0);
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (w_fifo_has_data) begin
          w_next_state = ST_SYNC;
          w_load_sync  = 1'b1;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (w_byte_end) begin
          if (!w_last_slot) begin
            w_next_state = ST_DATA;
            w_load_data  = 1'b1;
            w_pop        = w_fifo_has_data;
          end else if (w_fifo_has_data) begin
            w_next_state = ST_SYNC;
            w_load_sync  = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
            w_go_idle    = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_go_idle    = 1'b1;
      end
    endcase
  end

  // Bit divider, bit/slot counters, shift register and the underrun flag for the slot just loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= '0;
      r_bit      <= 3'd0;
      r_slot     <= '0;
      r_shift    <= 8'h00;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_load_sync) begin
        r_shift <= SYNC_WORD;
        r_bit   <= 3'd0;
        r_div   <= '0;
        r_slot  <= '0;
      end else if (w_load_data) begin
        r_shift    <= w_fifo_has_data ? w_fifo_dout : IDLE_CODE;
        r_underrun <= ~w_fifo_has_data;
        r_bit      <= 3'd0;
        r_div      <= '0;
        r_slot     <= (r_state == ST_SYNC) ? '0 : r_slot + c_slot_w'(1);
      end else if (w_go_idle) begin
        r_shift <= 8'h00;
        r_bit   <= 3'd0;
        r_div   <= '0;
        r_slot  <= '0;
      end else if (r_state != ST_IDLE) begin
        if (r_div == c_div_last) begin
          r_div   <= '0;
          r_bit   <= r_bit + 3'd1;
          r_shift <= {r_shift[6:0], 1'b0};
        end else begin
          r_div <= r_div + c_div_w'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire
